sdram_ctrl_fsm: RTL and testbench

- Sequencing controller for the SDRAM command encoder.
- Runs the power-up and initialisation sequence and keeps the refresh timer.
- Arbitrates between one write requester and one read requester.
- Drives init_state, work_state, cnt_clk and sdram_rd_wr; the command encoder turns these into pin-level commands one cycle later. Sits between the SDRAM FIFO/port logic and the command encoder.

---
 rtl/sdram_ctrl_fsm_pkg.sv | 66 ++++++
 rtl/sdram_ctrl_fsm_if.sv | 32 +++
 rtl/sdram_ctrl_fsm_ref_timer.sv | 36 +++
 rtl/sdram_ctrl_fsm.sv | 137 +++++++++++++
 tb/tb_sdram_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_ctrl_fsm_pkg.sv
// Shared definitions for the SDRAM sequencing controller: timing constants,
// init/work state codes, command encodings and the burst clamp helper.
package sdram_ctrl_fsm_pkg;

  localparam int T_POWERUP   = 20000;
  localparam int T_REF       = 781;
  localparam int T_RP        = 2;
  localparam int T_RFC       = 7;
  localparam int T_MRD       = 3;
  localparam int T_RCD       = 2;
  localparam int CAS_LAT     = 3;
  localparam int T_WR        = 2;
  localparam int INIT_AR_NUM = 8;
  localparam int BURST_MAX   = 256;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_e;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_e;

  // {cs_n, ras_n, cas_n, we_n} encodings used by the downstream command encoder
  typedef enum logic [3:0] {
    CMD_INIT   = 4'b1111,
    CMD_NOP    = 4'b0111,
    CMD_ACTIVE = 4'b0011,
    CMD_READ   = 4'b0101,
    CMD_WRITE  = 4'b0100,
    CMD_B_STOP = 4'b0110,
    CMD_PRGE   = 4'b0010,
    CMD_A_REF  = 4'b0001,
    CMD_LMR    = 4'b0000
  } cmd_e;

  // A zero-length burst still moves one word; anything past one page is cut to a page.
  function automatic logic [9:0] clamp_burst(input logic [9:0] len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > 10'(BURST_MAX))
      return 10'(BURST_MAX);
    else
      return len;
  endfunction

endpackage

// File: rtl/sdram_ctrl_fsm_if.sv
// Port bundle between the FIFO/port logic (master) and the sequencing controller (slave).
// Handshake: a requester raises its req level and holds it until the first matching
// ack; the controller answers with ack strobes (wr_ack = one word consumed per cycle,
// rd_ack = one word valid per cycle). The req must be low again before the transaction
// returns to idle, otherwise it is taken as a fresh request.
interface sdram_ctrl_fsm_if;
  import sdram_ctrl_fsm_pkg::*;

  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic [9:0]  sdram_wr_burst;
  logic [9:0]  sdram_rd_burst;
  init_e       init_state;
  work_e       work_state;
  logic [9:0]  cnt_clk;
  logic        sdram_rd_wr;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic        sdram_init_done;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
    input  init_state, work_state, cnt_clk, sdram_rd_wr,
    input  sdram_wr_ack, sdram_rd_ack, sdram_init_done
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
    output init_state, work_state, cnt_clk, sdram_rd_wr,
    output sdram_wr_ack, sdram_rd_ack, sdram_init_done
  );
endinterface

// File: rtl/sdram_ctrl_fsm_ref_timer.sv
// Auto-refresh interval timer. Runs once init is done and raises ref_pending every
// T_REF cycles; the flag stays up until the work FSM takes the refresh.
module sdram_ctrl_fsm_ref_timer
  import sdram_ctrl_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic clear,
  output logic ref_pending
);

  logic [9:0] ref_cnt;
  logic       expire;

  assign expire = init_done && (ref_cnt == 10'(T_REF - 1));

  // Interval counter wraps on expiry; a new expiry wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (expire)
        ref_cnt <= '0;
      else if (init_done)
        ref_cnt <= ref_cnt + 10'd1;

      if (expire)
        ref_pending <= 1'b1;
      else if (clear)
        ref_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM sequencing controller: power-up/init sequence, refresh scheduling and
// read/write arbitration. Outputs are state codes plus a per-state cycle counter
// that the command encoder turns into pin-level commands.
module sdram_ctrl_fsm
  import sdram_ctrl_fsm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sdram_ctrl_fsm_if.slave bus
);

  init_e       init_state, init_next;
  work_e       work_state, work_next;
  logic [9:0]  cnt_clk, cnt_next;
  logic [9:0]  burst, burst_m1;
  logic [14:0] pwr_cnt;
  logic [3:0]  ar_cnt;
  logic        pref_rd, rd_wr;
  logic        ref_pending;
  logic        grant_ar, grant_wr, grant_rd;
  logic        end_wrburst, end_rdburst;
  logic        wr_ack, rd_ack, init_done;

  assign burst_m1    = burst - 10'd1;
  assign end_wrburst = (work_state == W_WD) && (cnt_clk == burst_m1);
  assign end_rdburst = (work_state == W_RD) && (cnt_clk == burst_m1);

  sdram_ctrl_fsm_ref_timer u_ref_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .clear       (grant_ar),
    .ref_pending (ref_pending)
  );

  // Init sequence: power-up wait, precharge, INIT_AR_NUM refreshes, mode register set
  always_comb begin
    init_next = init_state;
    case (init_state)
      I_NOP:   if (pwr_cnt == 15'(T_POWERUP - 1)) init_next = I_PRE;
      I_PRE:   init_next = I_TRP;
      I_TRP:   if (cnt_clk == 10'(T_RP - 1)) init_next = I_AR;
      I_AR:    init_next = I_TRF;
      I_TRF:   if (cnt_clk == 10'(T_RFC - 1))
                 init_next = (ar_cnt == 4'(INIT_AR_NUM)) ? I_MRS : I_AR;
      I_MRS:   init_next = I_TRSC;
      I_TRSC:  if (cnt_clk == 10'(T_MRD - 1)) init_next = I_DONE;
      default: init_next = init_state;
    endcase
  end

  // Work FSM: arbitration in idle, then fixed command/wait chains per transaction type
  always_comb begin
    work_next = work_state;
    grant_ar  = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (init_state == I_DONE) begin
      case (work_state)
        W_IDLE: begin
          if (ref_pending) begin
            grant_ar  = 1'b1;
            work_next = W_AR;
          end else if (bus.sdram_wr_req && (!bus.sdram_rd_req || !pref_rd)) begin
            grant_wr  = 1'b1;
            work_next = W_ACTIVE;
          end else if (bus.sdram_rd_req) begin
            grant_rd  = 1'b1;
            work_next = W_ACTIVE;
          end
        end
        W_ACTIVE: work_next = W_TRCD;
        W_TRCD:   if (cnt_clk == 10'(T_RCD - 2)) work_next = rd_wr ? W_READ : W_WRITE;
        W_READ:   work_next = W_CL;
        W_CL:     if (cnt_clk == 10'(CAS_LAT - 1)) work_next = W_RD;
        W_RD:     if (end_rdburst) work_next = W_PRE;
        W_WRITE:  work_next = W_WD;
        W_WD:     if (end_wrburst) work_next = W_TWR;
        W_TWR:    if (cnt_clk == 10'(T_WR - 1)) work_next = W_PRE;
        W_PRE:    work_next = W_TRP;
        W_TRP:    if (cnt_clk == 10'(T_RP - 1)) work_next = W_IDLE;
        W_AR:     work_next = W_TRFC;
        W_TRFC:   if (cnt_clk == 10'(T_RFC - 1)) work_next = W_IDLE;
        default:  work_next = W_IDLE;
      endcase
    end
  end

  // Cycles-in-state counter restarts on any state change and saturates at 1023
  always_comb begin
    cnt_next = cnt_clk;
    if ((init_next != init_state) || (work_next != work_state))
      cnt_next = '0;
    else if (cnt_clk != 10'd1023)
      cnt_next = cnt_clk + 10'd1;
  end

  // State, counters, grant bookkeeping and acks, all registered from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_state <= I_NOP;
      work_state <= W_IDLE;
      cnt_clk    <= '0;
      pwr_cnt    <= '0;
      ar_cnt     <= '0;
      pref_rd    <= 1'b0;
      rd_wr      <= 1'b0;
      burst      <= 10'd1;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      init_state <= init_next;
      work_state <= work_next;
      cnt_clk    <= cnt_next;
      if (init_state == I_NOP) pwr_cnt <= pwr_cnt + 15'd1;
      if (init_state == I_AR)  ar_cnt  <= ar_cnt + 4'd1;
      if (grant_wr || grant_rd) begin
        rd_wr   <= grant_rd;
        pref_rd <= grant_wr;
        burst   <= clamp_burst(grant_rd ? bus.sdram_rd_burst : bus.sdram_wr_burst);
      end
      wr_ack    <= (work_next == W_WRITE) || ((work_next == W_WD) && (cnt_next < burst_m1));
      rd_ack    <= (work_next == W_RD);
      init_done <= (init_next == I_DONE);
    end
  end

  assign bus.init_state      = init_state;
  assign bus.work_state      = work_state;
  assign bus.cnt_clk         = cnt_clk;
  assign bus.sdram_rd_wr     = rd_wr;
  assign bus.sdram_wr_ack    = wr_ack;
  assign bus.sdram_rd_ack    = rd_ack;
  assign bus.sdram_init_done = init_done;

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Directed bench for sdram_ctrl_fsm: expected per-cycle traces of
// {work_state, wr_ack, rd_ack, rd_wr} are queued when a request is driven and
// popped against the DUT once the grant appears.
module tb_sdram_ctrl_fsm;

  localparam logic [3:0] S_IDLE = 4'd0, S_ACTIVE = 4'd1, S_TRCD = 4'd2, S_READ = 4'd3,
                         S_CL = 4'd4, S_RD = 4'd5, S_WRITE = 4'd6, S_WD = 4'd7,
                         S_TWR = 4'd8, S_PRE = 4'd9, S_TRP = 4'd10, S_AR = 4'd11,
                         S_TRFC = 4'd12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  sdram_ctrl_fsm_if bus();

  sdram_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] ent(input logic [3:0] s, input logic w, input logic r,
                                     input logic d);
    return {s, w, r, d};
  endfunction

  function automatic int clampb(input int b);
    if (b == 0) return 1;
    if (b > 256) return 256;
    return b;
  endfunction

  task automatic push_wr(input int b);
    int eb = clampb(b);
    exp_q.push_back(ent(S_ACTIVE, 0, 0, 0));
    exp_q.push_back(ent(S_TRCD, 0, 0, 0));
    exp_q.push_back(ent(S_WRITE, 1, 0, 0));
    for (int k = 0; k < eb; k++) exp_q.push_back(ent(S_WD, (k < eb - 1), 0, 0));
    repeat (2) exp_q.push_back(ent(S_TWR, 0, 0, 0));
    exp_q.push_back(ent(S_PRE, 0, 0, 0));
    repeat (2) exp_q.push_back(ent(S_TRP, 0, 0, 0));
    exp_q.push_back(ent(S_IDLE, 0, 0, 0));
  endtask

  task automatic push_rd(input int b);
    int eb = clampb(b);
    exp_q.push_back(ent(S_ACTIVE, 0, 0, 1));
    exp_q.push_back(ent(S_TRCD, 0, 0, 1));
    exp_q.push_back(ent(S_READ, 0, 0, 1));
    repeat (3) exp_q.push_back(ent(S_CL, 0, 0, 1));
    for (int k = 0; k < eb; k++) exp_q.push_back(ent(S_RD, 0, 1, 1));
    exp_q.push_back(ent(S_PRE, 0, 0, 1));
    repeat (2) exp_q.push_back(ent(S_TRP, 0, 0, 1));
    exp_q.push_back(ent(S_IDLE, 0, 0, 1));
  endtask

  task automatic push_ar(input logic d);
    exp_q.push_back(ent(S_AR, 0, 0, d));
    repeat (7) exp_q.push_back(ent(S_TRFC, 0, 0, d));
    exp_q.push_back(ent(S_IDLE, 0, 0, d));
  endtask

  // Call right after driving a request at a negedge; returns at the negedge showing ACTIVE
  task automatic wait_grant(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.work_state !== 4'(S_ACTIVE) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 32'(bus.work_state), 32'(S_ACTIVE));
  endtask

  // Pops the queue one entry per cycle; request lines change after the indexed entries
  task automatic drain(input string tag, input int drop_wr_at, input int drop_rd_at,
                       input int raise_rd_at, output int wr_n, output int rd_n);
    logic [6:0] e;
    logic [6:0] o;
    int i = 0;
    wr_n = 0;
    rd_n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = {bus.work_state, bus.sdram_wr_ack, bus.sdram_rd_ack, bus.sdram_rd_wr};
      chk($sformatf("%s[%0d]", tag, i), 32'(o), 32'(e));
      wr_n += int'(o[2]);
      rd_n += int'(o[1]);
      if (i == drop_wr_at) bus.sdram_wr_req = 1'b0;
      if (i == drop_rd_at) bus.sdram_rd_req = 1'b0;
      if (i == raise_rd_at) bus.sdram_rd_req = 1'b1;
      i++;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  // Call at the negedge where rst_n has just been released
  task automatic wait_init(input string tag);
    int cyc = 0;
    int ars = 0;
    while (bus.sdram_init_done !== 1'b1 && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      if (32'(bus.init_state) == 32'd3) ars++;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'd20071);
    chk({tag, "_ar_count"}, 32'(ars), 32'd8);
    chk({tag, "_state"}, 32'(bus.init_state), 32'd7);
    chk({tag, "_work_idle"}, 32'(bus.work_state), 32'(S_IDLE));
  endtask

  initial begin
    int wn, rn, n;
    bus.sdram_wr_req   = 1'b0;
    bus.sdram_rd_req   = 1'b0;
    bus.sdram_wr_burst = 10'd0;
    bus.sdram_rd_burst = 10'd0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_init_state", 32'(bus.init_state), 32'd0);
    chk("rst_work_state", 32'(bus.work_state), 32'(S_IDLE));
    chk("rst_cnt_clk", 32'(bus.cnt_clk), 32'd0);
    chk("rst_rd_wr", 32'(bus.sdram_rd_wr), 32'd0);
    chk("rst_wr_ack", 32'(bus.sdram_wr_ack), 32'd0);
    chk("rst_rd_ack", 32'(bus.sdram_rd_ack), 32'd0);
    chk("rst_init_done", 32'(bus.sdram_init_done), 32'd0);
    rst_n = 1'b1;
    wait_init("init1");

    // refresh expires mid-write with a read waiting: write, refresh, then read
    repeat (600) @(negedge clk);
    bus.sdram_wr_burst = 10'd256;
    bus.sdram_rd_burst = 10'd4;
    push_wr(256);
    push_ar(1'b0);
    push_rd(4);
    bus.sdram_wr_req = 1'b1;
    wait_grant("ref");
    drain("ref", 0, 274, 0, wn, rn);
    chk("ref_wr_acks", 32'(wn), 32'd256);
    chk("ref_rd_acks", 32'(rn), 32'd4);

    // single write, burst 8
    bus.sdram_wr_burst = 10'd8;
    push_wr(8);
    bus.sdram_wr_req = 1'b1;
    wait_grant("wr8");
    drain("wr8", 0, -1, -1, wn, rn);
    chk("wr8_acks", 32'(wn), 32'd8);

    // single read, burst 16
    bus.sdram_rd_burst = 10'd16;
    push_rd(16);
    bus.sdram_rd_req = 1'b1;
    wait_grant("rd16");
    drain("rd16", -1, 0, -1, wn, rn);
    chk("rd16_acks", 32'(rn), 32'd16);

    // both requests held: W, R, W, R
    bus.sdram_wr_burst = 10'd4;
    bus.sdram_rd_burst = 10'd4;
    push_wr(4);
    push_rd(4);
    push_wr(4);
    push_rd(4);
    bus.sdram_wr_req = 1'b1;
    bus.sdram_rd_req = 1'b1;
    wait_grant("alt");
    drain("alt", 40, 40, -1, wn, rn);
    chk("alt_wr_acks", 32'(wn), 32'd8);
    chk("alt_rd_acks", 32'(rn), 32'd8);

    // burst 0 becomes one word
    bus.sdram_wr_burst = 10'd0;
    push_wr(0);
    bus.sdram_wr_req = 1'b1;
    wait_grant("wr0");
    drain("wr0", 0, -1, -1, wn, rn);
    chk("wr0_acks", 32'(wn), 32'd1);

    // burst 300 clamps to one page
    bus.sdram_rd_burst = 10'd300;
    push_rd(300);
    bus.sdram_rd_req = 1'b1;
    wait_grant("rd300");
    drain("rd300", -1, 0, -1, wn, rn);
    chk("rd300_acks", 32'(rn), 32'd256);

    // reset pulse in the middle of a read burst
    bus.sdram_rd_burst = 10'd16;
    bus.sdram_rd_req = 1'b1;
    wait_grant("rst_rd");
    bus.sdram_rd_req = 1'b0;
    n = 0;
    while (bus.work_state !== 4'(S_RD) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_rd", 32'(bus.work_state), 32'(S_RD));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_init_state", 32'(bus.init_state), 32'd0);
    chk("mid_rst_work_state", 32'(bus.work_state), 32'(S_IDLE));
    chk("mid_rst_rd_ack", 32'(bus.sdram_rd_ack), 32'd0);
    chk("mid_rst_init_done", 32'(bus.sdram_init_done), 32'd0);
    chk("mid_rst_cnt_clk", 32'(bus.cnt_clk), 32'd0);
    rst_n = 1'b1;
    wait_init("init2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
